// File: rtl/simple_uart_tx_fifo.sv
// Byte FIFO + issue FSM in front of an 8N1 UART TX; optional sticky overflow via SIMPLE_UART_TX_FIFO_OVERFLOW_EN.
// Latency: byte pushed into an empty idle FIFO is issued (uart_value_write) the cycle after the push.
// Backpressure: in_ready = (level != DEPTH); one byte outstanding toward the transmitter until its done pulse.
module simple_uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     srst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               uart_value,
  output logic                     uart_value_write,
  input  logic                     uart_value_done,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic                     overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  state_t        state;
  state_t        state_nxt;
  logic          push;
  logic          issue;

  assign in_ready = (level != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign busy     = (level != '0) || (state == WAIT);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Done returns to IDLE only; the next issue needs a further edge.
        if (uart_value_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is deliberately not reset; only the pointers and level define occupancy.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (srst) begin
      state            <= IDLE;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      level            <= '0;
      uart_value       <= 8'h00;
      uart_value_write <= 1'b0;
    end else begin
      state            <= state_nxt;
      uart_value_write <= issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) begin
        rd_ptr     <= rd_ptr + 1'b1;
        uart_value <= mem[rd_ptr];
      end
      if (push && !issue)      level <= level + 1'b1;
      else if (!push && issue) level <= level - 1'b1;
    end
  end

`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
  always_ff @(posedge clock) begin
    if (srst)                       overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_simple_uart_tx_fifo.sv
// Self-checking bench for simple_uart_tx_fifo (DEPTH=4): vector table, scoreboarded transmitter model,
// and hand sequences for burst hold-off, push-on-issue wrap, reset mid-WAIT and overflow.
module tb_simple_uart_tx_fifo;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       srst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] uart_value;
  logic       uart_value_write;
  logic       uart_value_done;
  logic [2:0] level;
  logic       busy;
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
  logic       overflow;
`endif

  simple_uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .srst             (srst),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .uart_value       (uart_value),
    .uart_value_write (uart_value_write),
    .uart_value_done  (uart_value_done),
    .level            (level),
    .busy             (busy)
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
    ,
    .overflow         (overflow)
`endif
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];
  int         n_writes = 0;
  int         outstanding = 0;
  int         auto_done = 1;
  int         done_delay = 20;
  int         done_req = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: consumes write pulses against the scoreboard and returns done pulses.
  initial begin
    int cnt = 0;
    int done_ack = 0;
    uart_value_done = 1'b0;
    forever begin
      @(negedge clock);
      uart_value_done = 1'b0;
      if (srst) begin
        cnt = 0;
        outstanding = 0;
        done_ack = done_req;
      end else begin
        if (done_req != done_ack) begin
          done_ack = done_req;
          uart_value_done = 1'b1;
          outstanding = 0;
          cnt = 0;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            uart_value_done = 1'b1;
            outstanding = 0;
          end
        end
        if (uart_value_write) begin
          n_writes++;
          check("one_outstanding", outstanding, 0);
          if (sb.size() == 0) begin
            check("unexpected_write", int'(uart_value), -1);
          end else begin
            check("tx_data", int'(uart_value), int'(sb.pop_front()));
          end
          outstanding = 1;
          if (auto_done != 0) cnt = done_delay;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds in_valid until the byte is taken; returns how many cycles it was refused.
  task automatic push_byte(input logic [7:0] b, output int refused);
    logic acc;
    refused  = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 200; i++) begin
      acc = in_ready;
      tick();
      if (acc) break;
      refused++;
    end
    if (!acc) check("push_timeout", 0, 1);
    else sb.push_back(b);
  endtask

  task automatic wait_idle();
    int ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (!busy && sb.size() == 0 && outstanding == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("idle_timeout", ok, 1);
  endtask

  typedef struct {
    logic [7:0] dat;
    int         delay;
    logic [2:0] exp_level;
    logic [7:0] exp_value;
  } vec_t;

  initial begin
    vec_t       vecs [4];
    logic [7:0] burst [6];
    int         refused;
    int         exp_writes = 0;
    int         ok;

    vecs[0] = '{8'hA5, 20, 3'd1, 8'hA5};
    vecs[1] = '{8'h00,  3, 3'd1, 8'h00};
    vecs[2] = '{8'hFF,  1, 3'd1, 8'hFF};
    vecs[3] = '{8'h5A,  8, 3'd1, 8'h5A};
    burst   = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    srst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) tick();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_level", int'(level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_write", int'(uart_value_write), 0);
    check("rst_value", int'(uart_value), 0);
    srst = 1'b0;
    tick();

    // Single-byte issue timing
    for (int v = 0; v < 4; v++) begin
      done_delay = vecs[v].delay;
      push_byte(vecs[v].dat, refused);
      in_valid = 1'b0;
      check("vec_level", int'(level), int'(vecs[v].exp_level));
      check("vec_write_k", int'(uart_value_write), 0);
      check("vec_busy", int'(busy), 1);
      tick();
      check("vec_write_k1", int'(uart_value_write), 1);
      check("vec_value", int'(uart_value), int'(vecs[v].exp_value));
      tick();
      check("vec_write_k2", int'(uart_value_write), 0);
      check("vec_value_hold", int'(uart_value), int'(vecs[v].exp_value));
      wait_idle();
      exp_writes++;
      check("vec_busy_after", int'(busy), 0);
      check("vec_write_count", n_writes, exp_writes);
    end

    // Burst: priming byte goes out, next four fill the FIFO, 0x55 must wait
    done_delay = 20;
    for (int i = 0; i < 6; i++) begin
      push_byte(burst[i], refused);
      if (i == 4) begin
        check("burst_level_peak", int'(level), DEPTH);
        check("burst_full_ready", int'(in_ready), 0);
      end
      if (i == 5) begin
        check("burst_hold_off", int'(refused > 0), 1);
        check("burst_level_refill", int'(level), DEPTH);
      end
    end
    in_valid = 1'b0;
    wait_idle();
    exp_writes += 6;
    check("burst_write_count", n_writes, exp_writes);

    // Push on every issue edge with level 2; pointers wrap several times
    done_delay = 6;
    for (int i = 0; i < 3; i++) push_byte(8'h80 + 8'(i), refused);
    in_valid = 1'b0;
    check("wrap_level_init", int'(level), 2);
    for (int j = 0; j < 12; j++) begin
      ok = 0;
      for (int c = 0; c < 50; c++) begin
        if (uart_value_done) begin
          ok = 1;
          break;
        end
        tick();
      end
      check("wrap_done_seen", ok, 1);
      in_valid = 1'b1;
      in_data  = 8'h90 + 8'(j);
      sb.push_back(in_data);
      tick();
      in_valid = 1'b0;
      check("wrap_level", int'(level), 2);
      check("wrap_issue", int'(uart_value_write), 1);
    end
    wait_idle();
    exp_writes += 15;
    check("wrap_write_count", n_writes, exp_writes);

    // Reset in WAIT with three bytes queued
    auto_done = 0;
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i), refused);
    in_valid = 1'b0;
    exp_writes += 1;
    check("mid_level", int'(level), 3);
    check("mid_busy", int'(busy), 1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    sb.delete();
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      check("mid_no_write", int'(uart_value_write), 0);
      tick();
    end
    done_req++;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("late_done_no_write", int'(uart_value_write), 0);
    end
    check("late_done_busy", int'(busy), 0);
    check("late_done_level", int'(level), 0);
    check("mid_write_count", n_writes, exp_writes);

    // Fill, then offer one byte while full
    for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i), refused);
    check("ovf_full_level", int'(level), DEPTH);
    check("ovf_full_ready", int'(in_ready), 0);
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
    check("ovf_clear_before", int'(overflow), 0);
`endif
    in_data = 8'hEE;
    tick();
    in_valid = 1'b0;
    check("ovf_level_kept", int'(level), DEPTH);
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
    check("ovf_set", int'(overflow), 1);
`endif
    done_delay = 5;
    auto_done = 1;
    done_req++;
    wait_idle();
    exp_writes += 5;
    check("ovf_write_count", n_writes, exp_writes);
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
    check("ovf_sticky", int'(overflow), 1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("ovf_srst_clear", int'(overflow), 0);
`endif

    repeat (3) tick();
    check("final_queue_empty", sb.size(), 0);
    check("final_write_count", n_writes, exp_writes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
